// File: rtl/bram_sdp_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : bram_sdp_param_if
//  Brief    : Port A write / port B read / clear-control bundle for
//             bram_sdp_param.
//  Revision : 1.0  initial release
// ============================================================================
interface bram_sdp_param_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6
);
    logic                  wea;
    logic [DATA_W/8-1:0]   bea;
    logic [ADDR_W-1:0]     addra;
    logic [DATA_W-1:0]     dina;
    logic                  enb;
    logic [ADDR_W-1:0]     addrb;
    logic [DATA_W-1:0]     doutb;
    logic                  clr;
    logic                  init_busy;
    logic                  clr_done;

    modport master (
        output wea, bea, addra, dina, enb, addrb, clr,
        input  doutb, init_busy, clr_done
    );

    modport slave (
        input  wea, bea, addra, dina, enb, addrb, clr,
        output doutb, init_busy, clr_done
    );
endinterface
`default_nettype wire

// File: rtl/bram_sdp_param.sv
`default_nettype none
// ============================================================================
//  Module   : bram_sdp_param
//  Brief    : Parametrised simple-dual-port RAM with byte enables, selectable
//             collision mode, optional output register and a clear sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module bram_sdp_param #(
    parameter int                DATA_W   = 64,
    parameter int                ADDR_W   = 6,
    parameter int                WR_MODE  = 0,
    parameter int                OUT_REG  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  wire logic       clka,
    input  wire logic       rstn,
    bram_sdp_param_if.slave bus
);
    localparam int c_depth  = 2 ** ADDR_W;
    localparam int c_nbytes = DATA_W / 8;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_CLEAR = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_W-1:0]     r_cnt;
    logic                  r_clr_done;
    logic [DATA_W-1:0]     r_mem [c_depth];
    logic [DATA_W-1:0]     r_rd;
    logic                  w_cnt_last;
    logic                  w_we;
    logic [c_nbytes-1:0]   w_be;
    logic [ADDR_W-1:0]     w_wa;
    logic [DATA_W-1:0]     w_wd;
    logic [DATA_W-1:0]     w_rd_data;

    assign w_cnt_last = &r_cnt;

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The clear sequencer takes over port A entirely while in S_CLEAR.
    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_be        = '0;
        w_wa        = bus.addra;
        w_wd        = bus.dina;
        case (r_state)
            S_RST: begin
                w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                w_we = 1'b1;
                w_be = '1;
                w_wa = r_cnt;
                w_wd = INIT_VAL;
                if (!bus.clr && w_cnt_last) begin
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                w_we = bus.wea;
                w_be = bus.bea;
                if (bus.clr) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            default: begin
                w_state_nxt = S_RST;
            end
        endcase
    end

    // A clr pulse restarts the sweep; done is suppressed if it lands on the last write.
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            r_cnt      <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= (r_state == S_CLEAR) && w_cnt_last && !bus.clr;
            if ((r_state != S_CLEAR) || bus.clr) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clka) begin
        for (int i = 0; i < c_nbytes; i++) begin
            if (w_we && w_be[i]) begin
                r_mem[w_wa][8*i +: 8] <= w_wd[8*i +: 8];
            end
        end
    end

    generate
        if (WR_MODE == 1) begin : g_write_first
            always_comb begin
                w_rd_data = r_mem[bus.addrb];
                for (int i = 0; i < c_nbytes; i++) begin
                    if (w_we && w_be[i] && (w_wa == bus.addrb)) begin
                        w_rd_data[8*i +: 8] = w_wd[8*i +: 8];
                    end
                end
            end
        end else begin : g_read_first
            assign w_rd_data = r_mem[bus.addrb];
        end
    endgenerate

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            r_rd <= '0;
        end else if (bus.enb) begin
            r_rd <= w_rd_data;
        end
    end

    generate
        if (OUT_REG == 1) begin : g_out_reg
            logic [DATA_W-1:0] r_out;
            always_ff @(posedge clka or negedge rstn) begin
                if (!rstn) begin
                    r_out <= '0;
                end else begin
                    r_out <= r_rd;
                end
            end
            assign bus.doutb = r_out;
        end else begin : g_out_direct
            assign bus.doutb = r_rd;
        end
    endgenerate

    assign bus.init_busy = (r_state == S_CLEAR);
    assign bus.clr_done  = r_clr_done;

endmodule
`default_nettype wire

// File: doc/bram_sdp_param.md
Name: bram_sdp_param

Overview:
Parametrised simple-dual-port block RAM and the successor to the fixed 64x64 read-first BRAM. Port A writes and port B reads, both on one clock. Adds three things the fixed block lacks: selectable collision mode, per-byte write enables and an optional output register. A built-in clear sequencer fills the whole array with INIT_VAL after reset or on request. Used as register-file and buffer storage in the Lab5 datapath and SDU.

Parameters:
DATA_W, 64, data width in bits; must be a multiple of 8
ADDR_W, 6, address width; DEPTH = 2**ADDR_W entries
WR_MODE, 0, collision mode: 0 = read-first (old data), 1 = write-first (new data)
OUT_REG, 0, 1 adds an output pipeline register on doutb
INIT_VAL, 0, DATA_W-bit value written to every entry by the clear sequencer

Ports:
clka  in  1  clock for both ports
rstn  in  1  asynchronous active-low reset
wea  in  1  port A write enable
bea  in  DATA_W/8  port A byte enables; bit i covers dina[8i+7:8i]
addra  in  ADDR_W  port A write address
dina  in  DATA_W  port A write data
enb  in  1  port B read enable
addrb  in  ADDR_W  port B read address
doutb  out  DATA_W  port B read data
clr  in  1  single-cycle pulse; requests a full clear
init_busy  out  1  high while the clear sequencer owns port A
clr_done  out  1  one-cycle pulse after the last clear write

Behaviour:
- Reset (rstn=0, async):
  - doutb=0, init_busy=0, clr_done=0, clear counter=0, FSM=S_RST.
  - Array contents are not reset.
- FSM states: S_RST, S_CLEAR, S_READY.
  - S_RST -> S_CLEAR on the first clka edge with rstn=1; init_busy=1 in that same cycle.
  - S_CLEAR: each cycle writes INIT_VAL to mem[cnt] with all bytes enabled, then cnt++.
  - At cnt=DEPTH-1: that write completes, FSM -> S_READY, init_busy=0, clr_done pulses for 1 cycle on the following edge.
  - A full clear takes exactly DEPTH cycles.
  - S_READY -> S_CLEAR when clr=1; cnt resets to 0.
  - clr=1 while already in S_CLEAR restarts the count at 0.
- Port A write (S_READY only):
  - If wea=1 at a clka edge, for each i with bea[i]=1: mem[addra] byte i <= dina byte i.
  - Bytes with bea[i]=0 are unchanged.
  - wea=1 with bea=0 is a no-op.
  - wea is ignored while init_busy=1; the write is dropped, not queued.
- Port B read:
  - If enb=1 at edge N, the read register loads mem[addrb].
  - OUT_REG=0: data is visible on doutb after edge N (latency 1).
  - OUT_REG=1: data is visible after edge N+1 (latency 2).
  - enb=0: read register holds its value, and doutb holds.
  - The output register always advances; with OUT_REG=1 and enb=0 it re-presents the held value.
  - Reads are allowed during S_CLEAR and return the current array contents, using the same collision rule against the clear write.
- Collision (addra==addrb, write and read on the same edge):
  - WR_MODE=0: read returns pre-write contents.
  - WR_MODE=1: read returns post-write, byte-merged contents, i.e. unwritten bytes keep their old values.
- Addresses wrap naturally at DEPTH; no out-of-range condition exists.
- Reset asserted mid-clear aborts the clear. The sequence restarts from 0 after release.

Test Plan:
- Reset and init, ADDR_W=6, INIT_VAL=64'hA5: rstn low 3 cycles, then high -> init_busy=1 for exactly 64 cycles, clr_done pulses once; reads of addresses 0, 31 and 63 then return 64'hA5.
- Fill and readback, after init: write mem[a]=a+1 for a=0..63 with bea=8'hFF, then read addrb=0..63 -> doutb=a+1 one cycle after each read (OUT_REG=0), two cycles after (OUT_REG=1).
- Byte enables: mem[5]=64'h1111_2222_3333_4444; write dina=64'hFFFF_FFFF_FFFF_FFFF with bea=8'h0F -> read of 5 returns 64'h1111_2222_FFFF_FFFF.
- Collision: mem[7]=64'h10; same edge wea=1, dina=64'h20, addra=addrb=7, enb=1 -> doutb=64'h10 with WR_MODE=0, 64'h20 with WR_MODE=1; the next read returns 64'h20 in both modes.
- Clear interaction: in S_READY pulse clr, drive wea=1, addra=3, dina=64'h99 on the next cycle -> write dropped; after clr_done, mem[3]=INIT_VAL. Pulse clr again at cnt=20 -> init_busy stays high for a further 64 cycles.
- Reset mid-clear: drop rstn at cnt=10 -> doutb=0 and init_busy=0 immediately; after release, a fresh 64-cycle clear runs and ends with one clr_done pulse.
